ps2_device_tx: RTL and testbench
================================

PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 Parameter CLK_DIV, default 2500, sys_clk cycles per PS/2 clock half-period (legal 2..65535).
REQ-002 Parameter GAP_CYCLES, default 10000, sys_clk cycles of idle bus after each frame (legal 1..65535).
REQ-003 sys_clk  input  1  system clock; every register updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of sys_clk.
REQ-005 tx_data  input  8  byte to transmit (scan code); sampled only on the accept edge.
REQ-006 tx_valid  input  1  request to send tx_data.
REQ-007 tx_ready  output  1  high only in IDLE; the block accepts a byte on any edge where tx_valid and tx_ready are both high.
REQ-008 inhibit  input  1  host inhibit: high means the host is holding the bus.
REQ-009 kb_clk  output  1  PS/2 clock driven by the device, registered, push-pull.
REQ-010 kb_data  output  1  PS/2 data driven by the device, registered, push-pull.
REQ-011 tx_done  output  1  one-cycle pulse at the end of the gap after a frame completes.
REQ-012 tx_abort  output  1  one-cycle pulse when inhibit kills a frame.

Function
REQ-013 States: IDLE, HIGH (kb_clk=1, bit on kb_data), LOW (kb_clk=0, bit held), GAP (kb_clk=1, kb_data=1).
REQ-014 Frame of 11 bits, index 0..10: start 0; data bits D0..D7, LSB first; odd parity (XOR of the data bits, inverted); stop 1.
REQ-015 Accept edge E0 (tx_valid & tx_ready & ~inhibit): latch tx_data and go to HIGH with bit index 0; after E0, kb_data=0 and tx_ready=0.
REQ-016 HIGH lasts CLK_DIV cycles, then LOW. LOW lasts CLK_DIV cycles, then index+1 and HIGH, or GAP after index 10.
REQ-017 kb_data changes only on the HIGH-entry edge, never while kb_clk=0.
REQ-018 Bit n: kb_clk falls at edge E0+(2n+1)*CLK_DIV and rises at edge E0+(2n+2)*CLK_DIV.
REQ-019 Frame length is 22*CLK_DIV cycles. kb_clk is high and kb_data is 1 (stop bit) after edge E0+22*CLK_DIV.
REQ-020 GAP lasts GAP_CYCLES cycles, then IDLE. tx_done=1 and tx_ready=1 for the cycle after edge E0+22*CLK_DIV+GAP_CYCLES.
REQ-021 Back-to-back: tx_valid high in the tx_ready cycle is accepted at the next edge with no extra idle cycle.
REQ-022 tx_valid is ignored outside IDLE; changes on tx_data after E0 do not affect the frame in flight.
REQ-023 inhibit high in IDLE: tx_ready=0, no byte accepted.
REQ-024 inhibit sampled high in HIGH/LOW at index<=9: next edge kb_clk=1, kb_data=1, tx_abort pulses, enter GAP (full GAP_CYCLES), no tx_done.
REQ-025 inhibit during index 10 or GAP: ignored; the frame completes normally.
REQ-026 Half-period and gap counters are 16 bits and reload to zero on every state change. No wrap inside a state.
REQ-027 tx_done and tx_abort are never high in the same cycle.

Reset
REQ-028 On reset low: state IDLE, kb_clk=1, kb_data=1, tx_done=0, tx_abort=0, counters and index 0, latched byte 0x00.
REQ-029 tx_ready=0 while reset is low. In the first cycle after release, tx_ready=~inhibit.
REQ-030 Reset mid-frame takes effect at the next edge: bus released high, no tx_done/tx_abort pulse.

Verification (CLK_DIV=4, GAP_CYCLES=8; bench PS/2 sampler on kb_clk falling edge)
REQ-031 Send 0x1C -> falls at E0+4,12,...,84; sampled bits 0,0,0,1,1,1,0,0,0,0,1; tx_done at E0+96.
REQ-032 Send 0xF0 then 0x00 back-to-back -> parity 1 and 1, stop 1; second E0 one edge after the first tx_done; no glitch on kb_clk.
REQ-033 Send 0xFF and 0x01 -> parity 1 and 0; kb_data never changes while kb_clk=0.
REQ-034 Send 0x5A, inhibit high at E0+30 -> tx_abort pulses, bus high after next edge, tx_ready after 8 gap cycles, no tx_done.
REQ-035 Reset low at E0+40 during 0x1C -> kb_clk=1, kb_data=1, tx_ready=0 while reset low. A fresh 0x1C after release completes correctly.
REQ-036 tx_valid held with inhibit=1 in IDLE -> no kb_clk activity; release inhibit -> byte accepted on the next edge.

Source files
------------

// File: rtl/ps2_device_tx.sv
// ============================================================================
// Module   : ps2_device_tx
// Brief    : PS/2 device-side byte transmitter (11-bit odd-parity frame).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_device_tx #(
  parameter int unsigned CLK_DIV    = 2500,
  parameter int unsigned GAP_CYCLES = 10000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       inhibit,
  output logic       kb_clk,
  output logic       kb_data,
  output logic       tx_done,
  output logic       tx_abort
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [3:0]  LAST_IDX  = 4'd10;
  localparam logic [3:0]  PAR_IDX   = 4'd9;

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [3:0]  idx;
  logic [7:0]  data_q;
  logic        aborted;

  // Bit n of the frame: start, D0..D7, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] n);
    logic [3:0] k;
    k = n - 4'd1;
    case (n)
      4'd0:    frame_bit = 1'b0;
      PAR_IDX: frame_bit = ~(^d);
      LAST_IDX: frame_bit = 1'b1;
      default: frame_bit = d[k[2:0]];
    endcase
  endfunction

  assign tx_ready = reset & (state == ST_IDLE) & ~inhibit;

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= 16'd0;
      idx      <= 4'd0;
      data_q   <= 8'h00;
      aborted  <= 1'b0;
      kb_clk   <= 1'b1;
      kb_data  <= 1'b1;
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            data_q  <= tx_data;
            state   <= ST_HIGH;
            idx     <= 4'd0;
            cnt     <= 16'd0;
            aborted <= 1'b0;
            kb_clk  <= 1'b1;
            kb_data <= 1'b0;
          end
        end
        ST_HIGH, ST_LOW: begin
          // The host may only abort before the stop bit is on the wire.
          if (inhibit && idx <= PAR_IDX) begin
            state    <= ST_GAP;
            cnt      <= 16'd0;
            kb_clk   <= 1'b1;
            kb_data  <= 1'b1;
            tx_abort <= 1'b1;
            aborted  <= 1'b1;
          end else if (cnt != HALF_LAST) begin
            cnt <= cnt + 16'd1;
          end else if (state == ST_HIGH) begin
            state  <= ST_LOW;
            cnt    <= 16'd0;
            kb_clk <= 1'b0;
          end else if (idx == LAST_IDX) begin
            state   <= ST_GAP;
            cnt     <= 16'd0;
            kb_clk  <= 1'b1;
            kb_data <= 1'b1;
          end else begin
            state   <= ST_HIGH;
            cnt     <= 16'd0;
            idx     <= idx + 4'd1;
            kb_clk  <= 1'b1;
            kb_data <= frame_bit(data_q, idx + 4'd1);
          end
        end
        default: begin
          if (cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            cnt     <= 16'd0;
            idx     <= 4'd0;
            tx_done <= ~aborted;
            aborted <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_device_tx.sv
// ============================================================================
// Module   : tb_ps2_device_tx
// Brief    : Self-checking bench for ps2_device_tx against a timing model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_device_tx;

  localparam int D  = 4;
  localparam int G  = 8;
  localparam int FL = 22 * D;

  logic       sys_clk  = 1'b0;
  logic       reset    = 1'b0;
  logic       tx_valid = 1'b0;
  logic       inhibit  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready, kb_clk, kb_data, tx_done, tx_abort;

  int vectors     = 0;
  int miscompares = 0;
  int glitches    = 0;
  int overlaps    = 0;
  logic sampled[$];
  logic prev_data = 1'b1;

  always #5 sys_clk = ~sys_clk;

  ps2_device_tx #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .inhibit (inhibit),
    .kb_clk  (kb_clk),
    .kb_data (kb_data),
    .tx_done (tx_done),
    .tx_abort(tx_abort)
  );

  // Host-side sampler: data is read on each falling kb_clk.
  always @(negedge kb_clk) if (reset) sampled.push_back(kb_data);

  always @(negedge sys_clk) begin
    if (reset && kb_clk === 1'b0 && kb_data !== prev_data) glitches++;
    if (tx_done === 1'b1 && tx_abort === 1'b1) overlaps++;
    prev_data = kb_data;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Drives one byte and checks every cycle from the accept edge; stop_at >= 0 returns early.
  task automatic send_frame(input logic [7:0] b, input int stop_at);
    logic [10:0] f;
    logic [10:0] s;
    logic [4:0]  exp_v;
    logic [4:0]  got_v;
    int          half;
    f = frame_of(b);
    sampled.delete();
    tx_data  = b;
    tx_valid = 1'b1;
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_accept byte=%h got=%b want=1", b, tx_ready);
    end
    @(posedge sys_clk); #1;
    tx_valid = 1'b0;
    for (int k = 0; k <= FL + G; k++) begin
      if (k > 0) begin
        @(posedge sys_clk); #1;
      end
      tx_data = 8'($urandom);
      if (k < FL) begin
        half  = k / D;
        exp_v = {(half % 2 == 0), f[half/2], 1'b0, 1'b0, 1'b0};
      end else begin
        exp_v = {1'b1, 1'b1, (k == FL + G), (k == FL + G), 1'b0};
      end
      got_v = {kb_clk, kb_data, tx_done, tx_ready, tx_abort};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL frame_cycle byte=%h k=%0d {clk,data,done,ready,abort} got=%b want=%b",
                 b, k, got_v, exp_v);
      end
      if (k == stop_at) return;
    end
    s = '0;
    for (int i = 0; i < 11; i++) if (i < sampled.size()) s[i] = sampled[i];
    vectors++;
    if (sampled.size() != 11 || s !== f) begin
      miscompares++;
      $display("FAIL sampled_bits byte=%h count=%0d got=%b want=%b", b, sampled.size(), s, f);
    end
  endtask

  task automatic test_reset();
    logic [4:0] got_v;
    reset = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    got_v = {kb_clk, kb_data, tx_done, tx_abort, tx_ready};
    vectors++;
    if (got_v !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_state got=%b want=11000", got_v);
    end
    reset = 1'b1;
    @(posedge sys_clk); #1;
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release got=%b want=1", tx_ready);
    end
  endtask

  task automatic test_single();
    send_frame(8'h1C, -1);
  endtask

  task automatic test_back_to_back();
    send_frame(8'hF0, -1);
    send_frame(8'h00, -1);
    send_frame(8'hFF, -1);
    send_frame(8'h01, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) send_frame(8'($urandom), -1);
  endtask

  task automatic test_abort();
    logic [4:0] got_v;
    logic [4:0] exp_v;
    send_frame(8'h5A, 30);
    inhibit = 1'b1;
    @(posedge sys_clk); #1;
    inhibit = 1'b0;
    got_v = {kb_clk, kb_data, tx_done, tx_abort, tx_ready};
    vectors++;
    if (got_v !== 5'b11010) begin
      miscompares++;
      $display("FAIL abort_edge {clk,data,done,abort,ready} got=%b want=11010", got_v);
    end
    for (int j = 1; j <= G; j++) begin
      @(posedge sys_clk); #1;
      got_v = {kb_clk, kb_data, tx_done, tx_abort, tx_ready};
      exp_v = {1'b1, 1'b1, 1'b0, 1'b0, (j == G)};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL abort_gap j=%0d got=%b want=%b", j, got_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] got_v;
    send_frame(8'h1C, 40);
    reset = 1'b0;
    repeat (3) begin
      @(posedge sys_clk); #1;
      got_v = {kb_clk, kb_data, tx_done, tx_abort, tx_ready};
      vectors++;
      if (got_v !== 5'b11000) begin
        miscompares++;
        $display("FAIL reset_mid got=%b want=11000", got_v);
      end
    end
    reset = 1'b1;
    #1;
    send_frame(8'h1C, -1);
  endtask

  task automatic test_inhibit_idle();
    logic [2:0] got_v;
    inhibit  = 1'b1;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(posedge sys_clk); #1;
      got_v = {kb_clk, kb_data, tx_ready};
      vectors++;
      if (got_v !== 3'b110) begin
        miscompares++;
        $display("FAIL inhibit_idle j=%0d {clk,data,ready} got=%b want=110", j, got_v);
      end
    end
    inhibit = 1'b0;
    #1;
    send_frame(8'h3C, -1);
  endtask

  task automatic test_bus_rules();
    vectors++;
    if (glitches !== 0) begin
      miscompares++;
      $display("FAIL data_change_while_clk_low got=%0d want=0", glitches);
    end
    vectors++;
    if (overlaps !== 0) begin
      miscompares++;
      $display("FAIL done_abort_overlap got=%0d want=0", overlaps);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_abort();
    test_reset_mid();
    test_inhibit_idle();
    test_bus_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
